// File: rtl/otter_uart_pkg.sv
// ============================================================================
// Module   : otter_uart_pkg
// Purpose  : Shared state encoding and framing constants for the OTTER UART TX.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package otter_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/otter_uart_tx_fifo.sv
// ============================================================================
// Module   : otter_uart_tx_fifo
// Purpose  : Synchronous FIFO buffering bytes ahead of the UART serialiser.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module otter_uart_tx_fifo
  import otter_uart_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_pop_ok;
  logic w_push_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/otter_uart_tx.sv
// ============================================================================
// Module   : otter_uart_tx
// Purpose  : MMIO UART transmitter, FIFO-buffered, 8N1 LSB first.
//            Define OTTER_UART_PARITY_EN to append an even parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module otter_uart_tx
  import otter_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 clr_ovf,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 ovf,
  output logic                 tx
);

  localparam int                BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        c_last_bit  = 3'(DATA_BITS - 1);

  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  logic [BAUD_W-1:0]      r_baud;
  logic [2:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_tx;
  logic                   r_ovf;
  logic [DATA_BITS-1:0]   w_fifo_rdata;
  logic                   w_pop;
  logic                   w_tx_nxt;
  logic                   w_baud_done;
  logic                   w_drop;
`ifdef OTTER_UART_PARITY_EN
  logic                   r_parity;
`endif

  otter_uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  assign w_baud_done = (r_baud == c_baud_last);
  assign w_drop      = wr_en && full && !w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        if (!empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_done) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_done && (r_bit_cnt == c_last_bit)) begin
`ifdef OTTER_UART_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef OTTER_UART_PARITY_EN
      PARITY: begin
        w_tx_nxt = r_parity;
        if (w_baud_done) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_baud_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // TX is the registered copy of the current state's line level, so it trails the state by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tx      <= IDLE_LEVEL;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;

      if ((w_state_nxt != r_state) || (r_state == IDLE) || w_baud_done)
        r_baud <= '0;
      else
        r_baud <= r_baud + 1'b1;

      if (w_pop)
        r_shift <= w_fifo_rdata;
      else if ((r_state == DATA) && w_baud_done)
        r_shift <= r_shift >> 1;

      if (r_state != DATA)
        r_bit_cnt <= '0;
      else if (w_baud_done)
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

`ifdef OTTER_UART_PARITY_EN
  // The shift register is consumed during DATA, so parity is captured at pop time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_parity <= 1'b0;
    else if (w_pop) r_parity <= even_parity(w_fifo_rdata);
  end
`endif

  // A dropped write in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign busy = (r_state != IDLE);
  assign tx   = r_tx;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_otter_uart_tx.sv
// ============================================================================
// Module   : tb_otter_uart_tx
// Purpose  : Directed self-checking bench for otter_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_otter_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OTTER_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       full, empty, busy, ovf, tx;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mon_bad  = 0;
  int busy_cnt;
  int budget;
  logic [63:0] obs;

  logic [7:0] rx_data  [$];
  int         rx_start [$];
  logic       rx_par   [$];

  otter_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .ovf     (ovf),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_start.delete();
    rx_par.delete();
  endtask

  task automatic wait_frames(input int n, input string tag);
    int b;
    b = n * (FRAME_CYC + 2) + 50;
    while (rx_data.size() < n && b > 0) begin
      step();
      b--;
    end
    check(tag, 64'(rx_data.size()), 64'(n));
  endtask

  // Expected TX waveform, one bit per clock cycle, element 0 = first cycle of the start bit.
  function automatic logic [63:0] frame_wave(input logic [7:0] b);
    logic [63:0] w;
    logic        lvl;
    w = '0;
    for (int p = 0; p < FRAME_BITS; p++) begin
      if (p == 0)                    lvl = 1'b0;
      else if (p <= 8)               lvl = b[p-1];
      else if (p == FRAME_BITS - 1)  lvl = 1'b1;
      else                           lvl = ^b;
      for (int c = 0; c < CPB; c++) w[p*CPB + c] = lvl;
    end
    return w;
  endfunction

  // Line receiver: mid-bit sampling, discards frames disturbed by reset or bad framing.
  task automatic mon_tick(inout logic bad);
    @(posedge clk);
    #1;
    if (rst_n !== 1'b1) bad = 1'b1;
  endtask

  initial begin : g_monitor
    logic       bad;
    logic [7:0] d;
    logic       p;
    int         s;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        s   = cyc;
        bad = 1'b0;
        d   = '0;
        p   = 1'b0;
        repeat (CPB/2) mon_tick(bad);
        if (tx !== 1'b0) bad = 1'b1;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) mon_tick(bad);
          d[k] = tx;
        end
`ifdef OTTER_UART_PARITY_EN
        repeat (CPB) mon_tick(bad);
        p = tx;
`endif
        repeat (CPB) mon_tick(bad);
        if (tx !== 1'b1) bad = 1'b1;
        if (bad) mon_bad++;
        else begin
          rx_data.push_back(d);
          rx_start.push_back(s);
          rx_par.push_back(p);
        end
      end
    end
  end

  initial begin : g_watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();

    // 1: single frame, exact waveform and latency
    clear_rx();
    write_byte(8'h55);
    check("t1_empty_after_push", empty, 0);
    check("t1_tx_still_idle", tx, 1);
    step();
    check("t1_busy_after_pop", busy, 1);
    check("t1_empty_after_pop", empty, 1);
    busy_cnt = 1;
    obs = '0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      step();
      obs[i] = tx;
      if (busy) busy_cnt++;
    end
    check("t1_waveform", obs, frame_wave(8'h55));
    check("t1_busy_cycles", 64'(busy_cnt), 64'(FRAME_CYC));
    wait_frames(1, "t1_frames");
    if (rx_data.size() >= 1) check("t1_data", rx_data[0], 8'h55);

    // 2: back-to-back frames, one idle cycle between them
    repeat (5) step();
    clear_rx();
    write_byte(8'hA3);
    write_byte(8'h0F);
    wait_frames(2, "t2_frames");
    if (rx_data.size() >= 2) begin
      check("t2_data0", rx_data[0], 8'hA3);
      check("t2_data1", rx_data[1], 8'h0F);
      check("t2_gap", 64'(rx_start[1] - rx_start[0]), 64'(FRAME_CYC + 1));
    end

    // 3: overflow drop and clear
    repeat (5) step();
    clear_rx();
    for (int i = 0; i < 5; i++) write_byte(8'h11 + 8'(i));
    check("t3_full", full, 1);
    check("t3_ovf_before", ovf, 0);
    write_byte(8'h16);
    check("t3_ovf_set", ovf, 1);
    check("t3_full_kept", full, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", ovf, 0);
    wait_frames(5, "t3_frames");
    for (int i = 0; i < 5; i++)
      if (rx_data.size() > i) check("t3_data", rx_data[i], 8'h11 + 8'(i));
    repeat (3 * FRAME_CYC) step();
    check("t3_no_sixth", 64'(rx_data.size()), 5);
    check("t3_empty", empty, 1);
    check("t3_idle", busy, 0);

    // 4: write while full in the same cycle as a pop
    clear_rx();
    for (int i = 0; i < 5; i++) write_byte(8'h21 + 8'(i));
    check("t4_full", full, 1);
    budget = 2 * FRAME_CYC;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    check("t4_idle_seen", busy, 0);
    check("t4_full_at_pop", full, 1);
    wr_en   = 1'b1;
    wr_data = 8'h26;
    step();
    wr_en   = 1'b0;
    check("t4_full_after", full, 1);
    check("t4_ovf", ovf, 0);
    wait_frames(6, "t4_frames");
    for (int i = 0; i < 6; i++)
      if (rx_data.size() > i) check("t4_data", rx_data[i], 8'h21 + 8'(i));

    // 5: reset mid-frame
    repeat (5) step();
    clear_rx();
    write_byte(8'hFF);
    write_byte(8'h81);
    repeat (8) step();
    check("t5_busy_pre", busy, 1);
    check("t5_empty_pre", empty, 0);
    rst_n = 1'b0;
    #1;
    check("t5_tx_async", tx, 1);
    check("t5_busy_async", busy, 0);
    check("t5_empty_async", empty, 1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2 * FRAME_CYC) step();
    check("t5_no_frames", 64'(rx_data.size()), 0);
    check("t5_tx_idle", tx, 1);
    check("t5_busy_idle", busy, 0);
    check("t5_aborted", 64'(mon_bad), 1);

`ifdef OTTER_UART_PARITY_EN
    // 6: parity bit values
    clear_rx();
    write_byte(8'h07);
    write_byte(8'h03);
    wait_frames(2, "t6_frames");
    if (rx_data.size() >= 2) begin
      check("t6_data0", rx_data[0], 8'h07);
      check("t6_par0", rx_par[0], 1);
      check("t6_data1", rx_data[1], 8'h03);
      check("t6_par1", rx_par[1], 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
